// File: rtl/spi_poll_scheduler.sv
// Shares one SPI master between CPU single transactions and a round-robin driver status poll.
// Optional watchdog on stalled transfers: define SPI_SCHED_TIMEOUT_EN.
module spi_poll_scheduler #(
    parameter int              NUM_DRIVERS    = 12,
    parameter int              SIZE           = 40,
    parameter logic [SIZE-1:0] POLL_WORD      = 40'h6F00000000,
    parameter int              POLL_INTERVAL  = 25000,
    parameter int              TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   poll_enable_in,
    input  logic                   cpu_req_in,
    input  logic [SIZE-1:0]        cpu_data_in,
    input  logic [3:0]             cpu_cs_in,
    output logic                   r_cpu_busy_out,
    output logic                   r_cpu_done_out,
    output logic                   r_cpu_err_out,
    output logic [SIZE-1:0]        r_cpu_rdata_out,
    input  logic [3:0]             rd_sel_in,
    output logic [SIZE-1:0]        rd_data_out,
    output logic [NUM_DRIVERS-1:0] r_poll_valid_out,
    output logic [SIZE-1:0]        spi_data_out,
    output logic                   r_spi_send_enable_out,
    output logic [3:0]             spi_cs_select_out,
    input  logic [SIZE-1:0]        spi_data_in,
    input  logic                   spi_ready_in
);
    localparam int CW = $clog2(POLL_INTERVAL + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, CAPTURE} state_t;

    state_t                 state_q, state_d;
    logic                   job_cpu_q, job_cpu_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [SIZE-1:0]        rdata_q, rdata_d;
    logic [SIZE-1:0]        cpu_data_q, cpu_data_d;
    logic [3:0]             cpu_cs_q, cpu_cs_d;
    logic [3:0]             idx_q, idx_d, idx_nxt;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_DRIVERS-1:0] valid_q, valid_d;
    logic [SIZE-1:0]        res_q [NUM_DRIVERS];
    logic                   send_q;
    logic                   cap_en;
    logic                   cs_ok;
    logic                   poll_due;

    assign cs_ok    = {1'b0, cpu_cs_q} < 5'(NUM_DRIVERS);
    assign poll_due = poll_enable_in && (cnt_q == '0);
    assign idx_nxt  = (idx_q == 4'(NUM_DRIVERS - 1)) ? 4'd0 : idx_q + 4'd1;

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          waiting;
    logic          tmo_hit;

    assign waiting = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
    assign tmo_hit = waiting && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in)
            tmo_q <= '0;
        else if (waiting && !tmo_hit)
            tmo_q <= tmo_q + TW'(1);
        else
            tmo_q <= '0;
    end
`else
    wire unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d    = state_q;
        job_cpu_d  = job_cpu_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        rdata_d    = rdata_q;
        cpu_data_d = cpu_data_q;
        cpu_cs_d   = cpu_cs_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        cap_en     = 1'b0;
        cnt_d      = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        if (cpu_req_in && !busy_q) begin
            busy_d     = 1'b1;
            err_d      = 1'b0;
            cpu_data_d = cpu_data_in;
            cpu_cs_d   = cpu_cs_in;
        end
        unique case (state_q)
            IDLE: begin
                if (busy_q) begin
                    if (!cs_ok) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else if (spi_ready_in) begin
                        job_cpu_d = 1'b1;
                        state_d   = START;
                    end
                end else if (poll_due && !cpu_req_in && spi_ready_in) begin
                    // a same-cycle CPU strobe blocks the poll so the CPU goes first
                    job_cpu_d = 1'b0;
                    state_d   = START;
                end
            end
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (!spi_ready_in) state_d = WAIT_DONE;
            WAIT_DONE: if (spi_ready_in) state_d = CAPTURE;
            CAPTURE: begin
                state_d = IDLE;
                if (job_cpu_q) begin
                    rdata_d = spi_data_in;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    cap_en         = 1'b1;
                    valid_d[idx_q] = 1'b1;
                    idx_d          = idx_nxt;
                    cnt_d          = CW'(POLL_INTERVAL);
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef SPI_SCHED_TIMEOUT_EN
        if (tmo_hit) begin
            state_d = IDLE;
            if (job_cpu_q) begin
                err_d  = 1'b1;
                done_d = 1'b1;
                busy_d = 1'b0;
            end else begin
                valid_d[idx_q] = 1'b0;
                idx_d          = idx_nxt;
                cnt_d          = CW'(POLL_INTERVAL);
            end
        end
`endif
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            job_cpu_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            cpu_data_q <= '0;
            cpu_cs_q   <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= '0;
            send_q     <= 1'b0;
            for (int i = 0; i < NUM_DRIVERS; i++) res_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            job_cpu_q  <= job_cpu_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            cpu_data_q <= cpu_data_d;
            cpu_cs_q   <= cpu_cs_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            send_q     <= (state_d == START);
            if (cap_en) res_q[idx_q] <= spi_data_in;
        end
    end

    always_comb begin
        rd_data_out = '0;
        if ({1'b0, rd_sel_in} < 5'(NUM_DRIVERS)) rd_data_out = res_q[rd_sel_in];
    end

    assign spi_data_out          = job_cpu_q ? cpu_data_q : POLL_WORD;
    assign spi_cs_select_out     = job_cpu_q ? cpu_cs_q : idx_q;
    assign r_spi_send_enable_out = send_q;
    assign r_cpu_busy_out        = busy_q;
    assign r_cpu_done_out        = done_q;
    assign r_cpu_err_out         = err_q;
    assign r_cpu_rdata_out       = rdata_q;
    assign r_poll_valid_out      = valid_q;
endmodule

// File: tb/tb_spi_poll_scheduler.sv
// Directed bench for spi_poll_scheduler with a small behavioural SPI master model.
// Covers CPU jobs, invalid cs, round-robin polling, arbitration, reset and the watchdog.
module tb_spi_poll_scheduler;
    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        poll_enable_in;
    logic        cpu_req_in;
    logic [39:0] cpu_data_in;
    logic [3:0]  cpu_cs_in;
    logic        r_cpu_busy_out;
    logic        r_cpu_done_out;
    logic        r_cpu_err_out;
    logic [39:0] r_cpu_rdata_out;
    logic [3:0]  rd_sel_in;
    logic [39:0] rd_data_out;
    logic [11:0] r_poll_valid_out;
    logic [39:0] spi_data_out;
    logic        r_spi_send_enable_out;
    logic [3:0]  spi_cs_select_out;
    logic [39:0] rx = '0;
    logic        ready;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  cs_log[$];
    logic        fixed_en;
    logic        stuck;
    logic [39:0] fixed_word;
    int          mcnt;
    logic [3:0]  lat_cs;
    int          base;

    spi_poll_scheduler #(
        .NUM_DRIVERS(12), .SIZE(40), .POLL_WORD(40'h6F00000000),
        .POLL_INTERVAL(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in), .poll_enable_in(poll_enable_in),
        .cpu_req_in(cpu_req_in), .cpu_data_in(cpu_data_in), .cpu_cs_in(cpu_cs_in),
        .r_cpu_busy_out(r_cpu_busy_out), .r_cpu_done_out(r_cpu_done_out),
        .r_cpu_err_out(r_cpu_err_out), .r_cpu_rdata_out(r_cpu_rdata_out),
        .rd_sel_in(rd_sel_in), .rd_data_out(rd_data_out),
        .r_poll_valid_out(r_poll_valid_out), .spi_data_out(spi_data_out),
        .r_spi_send_enable_out(r_spi_send_enable_out),
        .spi_cs_select_out(spi_cs_select_out), .spi_data_in(rx),
        .spi_ready_in(ready)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (reset_in) begin
            ready <= 1'b1;
            mcnt  <= 0;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !stuck) begin
                ready <= 1'b1;
                rx    <= fixed_en ? fixed_word : 40'h100 + 40'(lat_cs);
            end
        end else if (r_spi_send_enable_out) begin
            ready  <= 1'b0;
            mcnt   <= 4;
            lat_cs <= spi_cs_select_out;
        end
    end

    always @(posedge clk_in)
        if (!reset_in && r_spi_send_enable_out) cs_log.push_back(spi_cs_select_out);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int bound, input string tag);
        int k = 0;
        while (r_cpu_done_out !== 1'b1 && k < bound) begin
            @(negedge clk_in);
            k++;
        end
        chk(tag, 64'(r_cpu_done_out), 64'd1);
    endtask

    task automatic wait_sends(input int n, input int bound, input string tag);
        int k = 0;
        while (cs_log.size() < n && k < bound) begin
            @(negedge clk_in);
            k++;
        end
        chk(tag, 64'(cs_log.size() >= n), 64'd1);
    endtask

    initial begin
        reset_in = 1'b1;
        poll_enable_in = 1'b0;
        cpu_req_in = 1'b0;
        cpu_data_in = '0;
        cpu_cs_in = '0;
        rd_sel_in = '0;
        fixed_en = 1'b1;
        fixed_word = 40'hA5A5A5A5A5;
        stuck = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_busy", 64'(r_cpu_busy_out), 0);
        chk("rst_done", 64'(r_cpu_done_out), 0);
        chk("rst_err", 64'(r_cpu_err_out), 0);
        chk("rst_rdata", 64'(r_cpu_rdata_out), 0);
        chk("rst_valid", 64'(r_poll_valid_out), 0);
        chk("rst_send", 64'(r_spi_send_enable_out), 0);
        reset_in = 1'b0;
        repeat (2) @(negedge clk_in);

        // CPU transaction, cs 3
        base = cs_log.size();
        cpu_req_in = 1'b1; cpu_cs_in = 4'd3; cpu_data_in = 40'h0123456789;
        @(negedge clk_in);
        chk("t1_busy", 64'(r_cpu_busy_out), 1);
        chk("t1_nosend_yet", 64'(r_spi_send_enable_out), 0);
        cpu_req_in = 1'b0;
        @(negedge clk_in);
        chk("t1_send", 64'(r_spi_send_enable_out), 1);
        chk("t1_cs", 64'(spi_cs_select_out), 3);
        chk("t1_data", 64'(spi_data_out), 64'h0123456789);
        wait_done(40, "t1_done_timeout");
        chk("t1_rdata", 64'(r_cpu_rdata_out), 64'hA5A5A5A5A5);
        chk("t1_busy_clr", 64'(r_cpu_busy_out), 0);
        chk("t1_err", 64'(r_cpu_err_out), 0);
        chk("t1_nsend", 64'(cs_log.size() - base), 1);
        @(negedge clk_in);
        chk("t1_done_pulse", 64'(r_cpu_done_out), 0);

        // invalid chip select, then a valid request clears err
        base = cs_log.size();
        cpu_req_in = 1'b1; cpu_cs_in = 4'd13;
        @(negedge clk_in);
        chk("t2_busy", 64'(r_cpu_busy_out), 1);
        cpu_req_in = 1'b0;
        @(negedge clk_in);
        chk("t2_done", 64'(r_cpu_done_out), 1);
        chk("t2_err", 64'(r_cpu_err_out), 1);
        chk("t2_busy_clr", 64'(r_cpu_busy_out), 0);
        chk("t2_nosend", 64'(cs_log.size() - base), 0);
        cpu_req_in = 1'b1; cpu_cs_in = 4'd4;
        @(negedge clk_in);
        chk("t2_err_clr", 64'(r_cpu_err_out), 0);
        cpu_req_in = 1'b0;
        wait_done(40, "t2_done_timeout");

        // round-robin polling
        fixed_en = 1'b0;
        base = cs_log.size();
        poll_enable_in = 1'b1;
        wait_sends(base + 13, 1000, "t3_sends_timeout");
        poll_enable_in = 1'b0;
        for (int i = 0; i < 13; i++)
            chk($sformatf("t3_cs%0d", i), 64'(cs_log[base+i]), 64'(i % 12));
        chk("t3_valid", 64'(r_poll_valid_out), 64'hFFF);
        rd_sel_in = 4'd5;
        #1 chk("t3_rd5", 64'(rd_data_out), 64'h105);
        rd_sel_in = 4'd11;
        #1 chk("t3_rd11", 64'(rd_data_out), 64'h10B);
        rd_sel_in = 4'd13;
        #1 chk("t3_rd13", 64'(rd_data_out), 0);
        rd_sel_in = 4'd5;

        // CPU request and due poll in the same cycle
        repeat (30) @(negedge clk_in);
        base = cs_log.size();
        cpu_req_in = 1'b1; cpu_cs_in = 4'd7; poll_enable_in = 1'b1;
        @(negedge clk_in);
        chk("t4_nopoll", 64'(r_spi_send_enable_out), 0);
        cpu_req_in = 1'b0;
        @(negedge clk_in);
        chk("t4_send", 64'(r_spi_send_enable_out), 1);
        chk("t4_cs", 64'(spi_cs_select_out), 7);
        wait_done(40, "t4_done_timeout");
        chk("t4_rdata", 64'(r_cpu_rdata_out), 64'h107);
        wait_sends(base + 2, 100, "t4_poll_timeout");
        chk("t4_first", 64'(cs_log[base]), 7);
        chk("t4_poll_idx", 64'(cs_log[base+1]), 1);

        // reset in WAIT_DONE
        wait_sends(base + 3, 100, "t5_send_timeout");
        repeat (2) @(negedge clk_in);
        reset_in = 1'b1;
        #1;
        chk("t5_send", 64'(r_spi_send_enable_out), 0);
        chk("t5_busy", 64'(r_cpu_busy_out), 0);
        chk("t5_rdata", 64'(r_cpu_rdata_out), 0);
        chk("t5_valid", 64'(r_poll_valid_out), 0);
        chk("t5_rd5", 64'(rd_data_out), 0);
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;
        base = cs_log.size();
        wait_sends(base + 1, 100, "t5_restart_timeout");
        chk("t5_cs0", 64'(cs_log[base]), 0);
        chk("t5_pollword", 64'(spi_data_out), 64'h6F00000000);

`ifdef SPI_SCHED_TIMEOUT_EN
        // watchdog with the SPI stuck busy
        poll_enable_in = 1'b0;
        repeat (30) @(negedge clk_in);
        stuck = 1'b1;
        cpu_req_in = 1'b1; cpu_cs_in = 4'd2;
        @(negedge clk_in);
        cpu_req_in = 1'b0;
        wait_done(100, "t6_done_timeout");
        chk("t6_err", 64'(r_cpu_err_out), 1);
        chk("t6_rdata", 64'(r_cpu_rdata_out), 0);
        chk("t6_busy", 64'(r_cpu_busy_out), 0);
        chk("t6_send", 64'(r_spi_send_enable_out), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
